bcd_key_entry: RTL
==================

BCD_KEY_ENTRY -- requirements
Module: bcd_key_entry

Interface
REQ-001 Parameter NDIG, default 4: number of BCD digits held, legal range 1..7.
REQ-002 Parameter DEB_CYCLES, default 4: number of consecutive stable cycles required for press and for release, legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 chk  in  1  key-valid flag from the upstream decimal encoder; asynchronous to clk.
REQ-006 din  in  4  BCD code from the upstream encoder; qualified by chk.
REQ-007 clr  in  1  synchronous clear of the entry buffer; synchronous to clk.
REQ-008 digits  out  4*NDIG  entered digits; newest digit in bits [3:0].
REQ-009 count  out  3  number of valid digits, saturating at NDIG.
REQ-010 full  out  1  high when count == NDIG.
REQ-011 key_stb  out  1  one-cycle pulse when a digit is accepted into digits.
REQ-012 err  out  1  one-cycle pulse when a debounced key is rejected.

Function
REQ-013 chk and din SHALL pass through a 2-flop synchronizer; all logic below uses the synchronized values (s_chk, s_din).
REQ-014 The FSM SHALL have states IDLE, PRESS, HELD and RELEASE, and a debounce counter of 8 bits.
REQ-015 IDLE: s_chk=1 -> PRESS; code latched from s_din; counter cleared.
REQ-016 PRESS: s_chk=0, or s_din differs from the latched code -> IDLE; counter == DEB_CYCLES-1 with s_chk=1 -> HELD plus an accept event; otherwise counter increments.
REQ-017 HELD: s_chk=0 -> RELEASE with counter cleared; s_chk=1 -> stay; a held key never generates a second accept event.
REQ-018 RELEASE: s_chk=1 -> HELD; counter == DEB_CYCLES-1 with s_chk=0 -> IDLE; otherwise counter increments.
REQ-019 Accept event with code <= 9 and count < NDIG: digits <= {digits[4*NDIG-5:0], code}; count increments; key_stb=1 for exactly one cycle.
REQ-020 Accept event with code > 9, or with full=1: digits and count unchanged; err=1 for one cycle; key_stb stays 0.
REQ-021 Latency: chk sampled high at edge k and stable -> key_stb high in the cycle after edge k+2+DEB_CYCLES; digits and count update on that same edge.
REQ-022 clr=1 SHALL zero digits and count on the next edge and takes priority over a simultaneous accept; in that case key_stb and err stay 0. The FSM state is not affected.
REQ-023 full SHALL be combinational from count; count never exceeds NDIG.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force: FSM=IDLE, counter=0, synchronizer flops=0, digits=0, count=0, full=0, key_stb=0, err=0.
REQ-025 Reset asserted mid-PRESS or mid-HELD SHALL discard the pending key; after release of reset, a still-pressed key is treated as a new press.

Configuration
REQ-026 Macro BCD_DEBOUNCE_EN: when defined, the debouncing of REQ-014..REQ-018 applies.
REQ-027 Without BCD_DEBOUNCE_EN, PRESS and RELEASE are bypassed and the counter is not built: IDLE with s_chk=1 -> HELD plus an accept event; HELD with s_chk=0 -> IDLE; the accept latency is 2 cycles after edge k.

Verification
REQ-028 Debounce on, DEB_CYCLES=4: chk=1, din=5 held for 20 cycles -> one key_stb at cycle k+6, digits[3:0]=5, count=1.
REQ-029 chk high for 2 cycles only (glitch) -> no key_stb, no err, digits unchanged.
REQ-030 Enter 1,2,3,4 then a fifth key of 7 -> digits=16'h1234, full=1, the fifth key gives err=1 and digits stay 16'h1234.
REQ-031 din=4'hB held valid -> err pulse only, count unchanged.
REQ-032 clr asserted on the same edge as an accepted key -> digits=0, count=0, key_stb=0.
REQ-033 rst_n=0 during HELD, then released with chk still high -> all outputs 0, then one new accept after the debounce delay.

Source files
------------

// File: rtl/bcd_key_entry.sv
// Debounced BCD keypad entry: synchronizes an async key strobe, accepts each
// key once and shifts it into a digit buffer. Debounce enabled by BCD_DEBOUNCE_EN.
module bcd_key_entry #(
  parameter int NDIG       = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chk,
  input  logic [3:0]        din,
  input  logic              clr,
  output logic [4*NDIG-1:0] digits,
  output logic [2:0]        count,
  output logic              full,
  output logic              key_stb,
  output logic              err
);

  localparam logic [2:0] NDIG_C = 3'(NDIG);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  logic       chk_m, s_chk;
  logic [3:0] din_m, s_din;
  state_t     state_q, state_d;
  logic       accept;
  logic [3:0] acc_code;
  logic [4*NDIG-1:0] digits_shift;

  // chk/din come from an unclocked encoder; the code is only trusted once
  // s_chk is stable, so a plain per-bit 2-flop chain is sufficient.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_m <= 1'b0;
      s_chk <= 1'b0;
      din_m <= '0;
      s_din <= '0;
    end else begin
      chk_m <= chk;
      s_chk <= chk_m;
      din_m <= din;
      s_din <= din_m;
    end
  end

`ifdef BCD_DEBOUNCE_EN
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic [3:0] code_q, code_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_chk) begin
          state_d = PRESS;
          code_d  = s_din;
          cnt_d   = '0;
        end
      end
      PRESS: begin
        // a code change mid-press is a bounce on the encoder lines
        if (!s_chk || (s_din != code_q)) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (!s_chk) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (s_chk) begin
          state_d = HELD;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc_code = code_q;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_chk) begin
          state_d = HELD;
          accept  = 1'b1;
        end
      end
      HELD: begin
        if (!s_chk) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc_code = s_din;
`endif

  generate
    if (NDIG > 1) begin : g_shift
      assign digits_shift = {digits[4*NDIG-5:0], acc_code};
    end else begin : g_single
      assign digits_shift = acc_code;
    end
  endgenerate

  assign full = (count == NDIG_C);

  // clr wins over a same-edge accept and silences both strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits  <= '0;
      count   <= '0;
      key_stb <= 1'b0;
      err     <= 1'b0;
    end else begin
      key_stb <= 1'b0;
      err     <= 1'b0;
      if (clr) begin
        digits <= '0;
        count  <= '0;
      end else if (accept) begin
        if ((acc_code <= 4'd9) && !full) begin
          digits  <= digits_shift;
          count   <= count + 3'd1;
          key_stb <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule
